operand_sequencer: RTL

//  Front-end stage feeding the 4-bit logic unit. Builds its 8-bit operand word z and 2-bit select

---
 rtl/operand_sequencer_pkg.sv | 15 +
 rtl/operand_sequencer_btn_sync_edge.sv | 29 ++
 rtl/operand_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/operand_sequencer_pkg.sv
// Shared encodings and default widths for the operand sequencer, logic unit and display code.
package operand_sequencer_pkg;

    localparam int unsigned NIB_W = 4;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_X   = 2'd0,
        S_Y   = 2'd1,
        S_OP  = 2'd2,
        S_RDY = 2'd3
    } state_t;

endpackage

// File: rtl/operand_sequencer_btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous push-button with a one-cycle rising-edge pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic level,
    output logic rise_c
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign level  = sync2_q;
    assign rise_c = sync2_q & ~prev_q;

endmodule

// File: rtl/operand_sequencer.sv
// Captures x, y and opcode from the switch bank on successive load presses and presents {x,y}/select.
module operand_sequencer #(
    parameter int unsigned NIB_W = operand_sequencer_pkg::NIB_W,
    parameter int unsigned SEL_W = operand_sequencer_pkg::SEL_W,
    parameter int unsigned CNT_W = operand_sequencer_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NIB_W-1:0]     data_in,
    input  logic                 load_btn,
    input  logic                 clear_btn,
    output logic [2*NIB_W-1:0]   z,
    output logic [SEL_W-1:0]     select,
    output logic                 ready,
    output logic [1:0]           phase,
    output logic [CNT_W-1:0]     op_count
);

    import operand_sequencer_pkg::*;

    logic load_rise;
    logic load_level_unused;
    logic clear_level;
    logic clear_rise_unused;
    logic load_pulse;

    state_t             state_q, state_d;
    logic [NIB_W-1:0]   x_q, x_d;
    logic [NIB_W-1:0]   y_q, y_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               ready_q, ready_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    btn_sync_edge u_load_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (load_btn),
        .level   (load_level_unused),
        .rise_c  (load_rise)
    );

    btn_sync_edge u_clear_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (clear_btn),
        .level   (clear_level),
        .rise_c  (clear_rise_unused)
    );

    // A coincident clear swallows the load edge.
    assign load_pulse = load_rise & ~clear_level;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_X;
            x_q     <= '0;
            y_q     <= '0;
            sel_q   <= '0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath capture; ready drops with the x update of a new set.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sel_d   = sel_q;
        ready_d = ready_q;
        cnt_d   = cnt_q;
        if (clear_level) begin
            state_d = S_X;
            x_d     = '0;
            y_d     = '0;
            sel_d   = '0;
            ready_d = 1'b0;
            cnt_d   = '0;
        end else if (load_pulse) begin
            case (state_q)
                S_X: begin
                    x_d     = data_in;
                    state_d = S_Y;
                end
                S_Y: begin
                    y_d     = data_in;
                    state_d = S_OP;
                end
                S_OP: begin
                    sel_d   = data_in[SEL_W-1:0];
                    ready_d = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_RDY;
                end
                S_RDY: begin
                    x_d     = data_in;
                    ready_d = 1'b0;
                    state_d = S_Y;
                end
                default: state_d = S_X;
            endcase
        end
    end

    assign z        = {x_q, y_q};
    assign select   = sel_q;
    assign ready    = ready_q;
    assign phase    = state_q;
    assign op_count = cnt_q;

endmodule
